// File: rtl/conv2d_sched_pkg.sv
// Shared constants, default geometry and FSM encoding for the conv2d tap scheduler.
package conv2d_sched_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_HEIGHT   = 32;
    localparam int DEF_CHANNELS = 3;
    localparam int DEF_FILTERS  = 16;
    localparam int DEF_K        = 3;
    localparam int DEF_PAD      = 1;
    localparam int DEF_ROM_LAT  = 2;

    localparam int IMG_AW  = 10;
    localparam int KER_AW  = 9;
    localparam int BIAS_AW = 4;
    localparam int CHAN_W  = 2;
    localparam int FILT_W  = 4;
    localparam int ROW_W   = 5;
    localparam int COL_W   = 5;
    localparam int KIDX_W  = 4;
    localparam int CNT_W   = 4;
    // Wide enough that -1 and HEIGHT/WIDTH stay distinguishable from in-range values
    localparam int COORD_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_TAP,
        ST_DRAIN,
        ST_WAIT_OUT,
        ST_DONE
    } sched_state_t;

    function automatic logic in_range(input logic signed [COORD_W-1:0] v, input int lim);
        return (v >= 0) && (int'(v) < lim);
    endfunction

endpackage

// File: rtl/conv2d_tap_sched_if.sv
// Control/address bundle between the tap scheduler (slave side) and its user/ROM datapath.
interface conv2d_tap_sched_if;
    import conv2d_sched_pkg::*;

    logic                start;
    logic                busy;
    logic                done;
    logic [IMG_AW-1:0]   image_addr;
    logic [KER_AW-1:0]   kernel_addr;
    logic [BIAS_AW-1:0]  bias_addr;
    logic                bias_valid;
    logic                tap_valid;
    logic                tap_first;
    logic [CHAN_W-1:0]   tap_chan;
    logic                out_valid;
    logic                out_ready;
    logic [FILT_W-1:0]   out_filt;
    logic [ROW_W-1:0]    out_row;
    logic [COL_W-1:0]    out_col;

    modport slave (
        input  start, out_ready,
        output busy, done, image_addr, kernel_addr, bias_addr, bias_valid,
               tap_valid, tap_first, tap_chan, out_valid, out_filt, out_row, out_col
    );

    modport master (
        output start, out_ready,
        input  busy, done, image_addr, kernel_addr, bias_addr, bias_valid,
               tap_valid, tap_first, tap_chan, out_valid, out_filt, out_row, out_col
    );

endinterface

// File: rtl/conv2d_lat_pipe.sv
// Fixed-depth delay line aligning slot flags with ROM data return.
module conv2d_lat_pipe #(
    parameter int LAT = 2,
    parameter int CW  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic          first_i,
    input  logic          bias_i,
    input  logic [CW-1:0] chan_i,
    output logic          valid_o,
    output logic          first_o,
    output logic          bias_o,
    output logic [CW-1:0] chan_o
);

    localparam int DW = CW + 3;

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            logic [DW-1:0] stage_q;
            logic [DW-1:0] stage_d;

            if (gi == 0) begin : g_head
                assign stage_d = {valid_i, first_i, bias_i, chan_i};
            end else begin : g_link
                assign stage_d = g_stage[gi-1].stage_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stage_q <= '0;
                else        stage_q <= stage_d;
            end
        end
    endgenerate

    assign {valid_o, first_o, bias_o, chan_o} = g_stage[LAT-1].stage_q;

endmodule

// File: rtl/conv2d_tap_sched.sv
// Walks every filter/pixel/tap of a padded KxK convolution, issuing ROM addresses and aligned beat flags.
// Optional CONV_SCHED_PERF_EN adds perf_cycles/perf_beats counters.
module conv2d_tap_sched
    import conv2d_sched_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int FILTERS  = DEF_FILTERS,
    parameter int K        = DEF_K,
    parameter int PAD      = DEF_PAD,
    parameter int ROM_LAT  = DEF_ROM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    conv2d_tap_sched_if.slave bus
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_beats
`endif
);

    sched_state_t        state_q;
    logic [FILT_W-1:0]   f_q;
    logic [ROW_W-1:0]    i_q;
    logic [COL_W-1:0]    j_q;
    logic [KIDX_W-1:0]   m_q;
    logic [KIDX_W-1:0]   n_q;
    logic [CHAN_W-1:0]   c_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                seen_q;
    logic                busy_q;
    logic                done_q;
    logic                out_valid_q;

    logic signed [COORD_W-1:0] in_y;
    logic signed [COORD_W-1:0] in_x;
    logic in_bounds, tap_slot, last_slot, last_col, last_row, last_filt, lat_end;
    logic accept, bias_push;
    logic pipe_valid, pipe_first, pipe_bias;
    logic [CHAN_W-1:0] pipe_chan;

    assign in_y = $signed(COORD_W'(i_q)) + $signed(COORD_W'(m_q)) - $signed(COORD_W'(PAD));
    assign in_x = $signed(COORD_W'(j_q)) + $signed(COORD_W'(n_q)) - $signed(COORD_W'(PAD));

    assign in_bounds = in_range(in_y, HEIGHT) && in_range(in_x, WIDTH);
    assign tap_slot  = (state_q == ST_TAP) && in_bounds;
    assign last_slot = (m_q == KIDX_W'(K-1)) && (n_q == KIDX_W'(K-1)) && (c_q == CHAN_W'(CHANNELS-1));
    assign last_col  = (j_q == COL_W'(WIDTH-1));
    assign last_row  = (i_q == ROW_W'(HEIGHT-1));
    assign last_filt = (f_q == FILT_W'(FILTERS-1));
    assign lat_end   = (cnt_q == CNT_W'(ROM_LAT-1));
    assign accept    = (state_q == ST_WAIT_OUT) && bus.out_ready;
    // Bias marker enters the pipe on the edge into BIAS so it surfaces on the last BIAS cycle
    assign bias_push = ((state_q == ST_IDLE) && bus.start) || (accept && last_col && last_row && !last_filt);

    assign bus.image_addr  = tap_slot ? IMG_AW'(int'(in_y) * WIDTH + int'(in_x)) : '0;
    assign bus.kernel_addr = tap_slot ?
        KER_AW'(((int'(m_q) * K + int'(n_q)) * CHANNELS + int'(c_q)) * FILTERS + int'(f_q)) : '0;
    assign bus.bias_addr   = f_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_filt    = f_q;
    assign bus.out_row     = i_q;
    assign bus.out_col     = j_q;
    assign bus.tap_valid   = pipe_valid;
    assign bus.tap_first   = pipe_first;
    assign bus.tap_chan    = pipe_chan;
    assign bus.bias_valid  = pipe_bias;

    conv2d_lat_pipe #(
        .LAT (ROM_LAT),
        .CW  (CHAN_W)
    ) u_lat_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (tap_slot),
        .first_i (tap_slot && !seen_q),
        .bias_i  (bias_push),
        .chan_i  (c_q),
        .valid_o (pipe_valid),
        .first_o (pipe_first),
        .bias_o  (pipe_bias),
        .chan_o  (pipe_chan)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            f_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            m_q         <= '0;
            n_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_BIAS;
                        f_q     <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        m_q     <= '0;
                        n_q     <= '0;
                        c_q     <= '0;
                        cnt_q   <= '0;
                        seen_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_BIAS: begin
                    if (lat_end) begin
                        state_q <= ST_TAP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_TAP: begin
                    if (in_bounds) seen_q <= 1'b1;
                    // Every slot costs a cycle, in or out of bounds, so pixel timing is constant
                    if (last_slot) begin
                        state_q <= ST_DRAIN;
                        m_q     <= '0;
                        n_q     <= '0;
                        c_q     <= '0;
                    end else if (c_q == CHAN_W'(CHANNELS-1)) begin
                        c_q <= '0;
                        if (n_q == KIDX_W'(K-1)) begin
                            n_q <= '0;
                            m_q <= m_q + KIDX_W'(1);
                        end else begin
                            n_q <= n_q + KIDX_W'(1);
                        end
                    end else begin
                        c_q <= c_q + CHAN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (lat_end) begin
                        state_q     <= ST_WAIT_OUT;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        seen_q      <= 1'b0;
                        if (!last_col) begin
                            j_q     <= j_q + COL_W'(1);
                            state_q <= ST_TAP;
                        end else if (!last_row) begin
                            j_q     <= '0;
                            i_q     <= i_q + ROW_W'(1);
                            state_q <= ST_TAP;
                        end else if (!last_filt) begin
                            j_q     <= '0;
                            i_q     <= '0;
                            f_q     <= f_q + FILT_W'(1);
                            state_q <= ST_BIAS;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    f_q     <= '0;
                    i_q     <= '0;
                    j_q     <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_beats  <= '0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            perf_cycles <= '0;
            perf_beats  <= '0;
        end else begin
            if (busy_q)     perf_cycles <= perf_cycles + 32'd1;
            if (pipe_valid) perf_beats  <= perf_beats + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv2d_tap_sched.sv
// Scoreboard bench for conv2d_tap_sched on a reduced geometry; expected beats come from a loop-nest model.
module tb_conv2d_tap_sched;
    import conv2d_sched_pkg::*;

    localparam int W = 10, H = 8, C = 3, F = 4, K = 3, P = 1, L = 2;
    localparam int BUDGET = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv2d_tap_sched_if bus();
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_beats;
`endif

    conv2d_tap_sched #(
        .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .FILTERS(F), .K(K), .PAD(P), .ROM_LAT(L)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CONV_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_beats  (perf_beats)
`endif
    );

    typedef struct {
        int img;
        int ker;
        int chan;
        int first;
    } beat_t;

    beat_t exp_beats[$];
    int    exp_pix[$];
    int    exp_bias[$];
    int    model_beats, model_pixels;

    int tests = 0, fails = 0;
    int cyc = 0, beat_cnt = 0, done_cnt = 0;
    int stalls = 0, stall_total = 0, last_acc = 0, have_prev = 0, prev_f = 0;
    int prev_ov = 0, prev_ready = 0, prev_coord = 0;
    int hist_img[$], hist_ker[$];

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Plain enumeration of the convolution: every in-bounds (m,n,c) of every pixel is one beat.
    task automatic build_model();
        exp_beats.delete();
        exp_pix.delete();
        exp_bias.delete();
        model_beats  = 0;
        model_pixels = 0;
        for (int f = 0; f < F; f++) begin
            exp_bias.push_back(f);
            for (int i = 0; i < H; i++) begin
                for (int j = 0; j < W; j++) begin
                    int first = 1;
                    exp_pix.push_back(f * 10000 + i * 100 + j);
                    model_pixels++;
                    for (int m = 0; m < K; m++)
                        for (int n = 0; n < K; n++)
                            for (int c = 0; c < C; c++) begin
                                int y = i - P + m;
                                int x = j - P + n;
                                if (y >= 0 && y < H && x >= 0 && x < W) begin
                                    beat_t b;
                                    b.img   = y * W + x;
                                    b.ker   = ((m * K + n) * C + c) * F + f;
                                    b.chan  = c;
                                    b.first = first;
                                    exp_beats.push_back(b);
                                    first = 0;
                                    model_beats++;
                                end
                            end
                end
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        beat_t e;
        int coord;
        cyc++;
        if (!rst_n) begin
            hist_img.delete();
            hist_ker.delete();
            prev_ov   = 0;
            have_prev = 0;
            stalls    = 0;
        end else begin
            if (bus.start && !bus.busy) begin
                beat_cnt    = 0;
                stall_total = 0;
                stalls      = 0;
                have_prev   = 0;
            end
            if (bus.tap_valid) begin
                beat_cnt++;
                if (exp_beats.size() == 0) begin
                    check("beat_extra", 1, 0);
                end else begin
                    e = exp_beats.pop_front();
                    check("beat_img", (hist_img.size() == L) ? hist_img[0] : -1, e.img);
                    check("beat_ker", (hist_ker.size() == L) ? hist_ker[0] : -1, e.ker);
                    check("beat_chan", int'(bus.tap_chan), e.chan);
                    check("beat_first", int'(bus.tap_first), e.first);
                end
            end
            hist_img.push_back(int'(bus.image_addr));
            hist_ker.push_back(int'(bus.kernel_addr));
            while (hist_img.size() > L) begin
                void'(hist_img.pop_front());
                void'(hist_ker.pop_front());
            end
            if (bus.bias_valid) begin
                if (exp_bias.size() == 0) check("bias_extra", 1, 0);
                else                      check("bias_addr", int'(bus.bias_addr), exp_bias.pop_front());
            end
            coord = int'(bus.out_filt) * 10000 + int'(bus.out_row) * 100 + int'(bus.out_col);
            if (bus.out_valid) begin
                if (prev_ov != 0 && prev_ready == 0) begin
                    check("hold_coord", coord, prev_coord);
                    check("hold_addr", int'(bus.image_addr) + int'(bus.kernel_addr), 0);
                end
                if (bus.out_ready) begin
                    if (exp_pix.size() == 0) check("pix_extra", 1, 0);
                    else                     check("pix_coord", coord, exp_pix.pop_front());
                    if (have_prev != 0)
                        check("pix_interval", cyc - last_acc,
                              28 + L + stalls + ((int'(bus.out_filt) != prev_f) ? L : 0));
                    $display("[TB] pixel f=%0d row=%0d col=%0d stalls=%0d t=%0d",
                             bus.out_filt, bus.out_row, bus.out_col, stalls, cyc);
                    have_prev = 1;
                    last_acc  = cyc;
                    prev_f    = int'(bus.out_filt);
                    stalls    = 0;
                end else begin
                    stalls++;
                    stall_total++;
                end
            end
            prev_ov    = int'(bus.out_valid);
            prev_ready = int'(bus.out_ready);
            prev_coord = coord;
            if (bus.done) begin
                done_cnt++;
                have_prev = 0;
`ifdef CONV_SCHED_PERF_EN
                check("perf_beats", int'(perf_beats), model_beats);
                check("perf_cycles", int'(perf_cycles), F * L + model_pixels * (28 + L) + stall_total);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high; 1: random ready and stray starts; 2: 10-cycle stall at (3,5,7)
    task automatic run_pass(input int mode, input string tag);
        int d0, stall_left, stalled_once, n;
        build_model();
        d0 = done_cnt;
        stall_left = 0;
        stalled_once = 0;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < BUDGET) begin
            case (mode)
                1: begin
                    bus.out_ready = ($urandom_range(3) != 0);
                    bus.start     = bus.busy && ($urandom_range(15) == 0);
                end
                2: begin
                    if (stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else if (bus.out_valid && stalled_once == 0 && bus.out_filt == 4'd3 &&
                                 bus.out_row == 5'd5 && bus.out_col == 5'd7) begin
                        bus.out_ready = 1'b0;
                        stall_left = 9;
                        stalled_once = 1;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
            tick();
            n++;
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, "_done_seen"}, done_cnt - d0, 1);
        repeat (4) tick();
        check({tag, "_done_single"}, done_cnt - d0, 1);
        check({tag, "_beats_total"}, beat_cnt, model_beats);
        check({tag, "_beats_left"}, exp_beats.size(), 0);
        check({tag, "_pix_left"}, exp_pix.size(), 0);
        check({tag, "_bias_left"}, exp_bias.size(), 0);
        check({tag, "_idle_busy"}, int'(bus.busy), 0);
        if (mode == 2) check("stall_hit", stalled_once, 1);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_tap_valid", int'(bus.tap_valid), 0);
        check("rst_bias_valid", int'(bus.bias_valid), 0);
        check("rst_addr", int'(bus.image_addr) + int'(bus.kernel_addr) + int'(bus.bias_addr), 0);
        check("rst_coord", int'(bus.out_filt) + int'(bus.out_row) + int'(bus.out_col), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        run_pass(0, "ready1");
        run_pass(1, "random");
        run_pass(2, "stall");

        build_model();
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat ($urandom_range(400, 50)) tick();
        n = 0;
        while (!bus.tap_valid && n < 100) begin
            tick();
            n++;
        end
        check("midpass_tap_seen", int'(bus.tap_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_tap_valid", int'(bus.tap_valid), 0);
        check("midrst_bias_valid", int'(bus.bias_valid), 0);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_addr", int'(bus.image_addr) + int'(bus.kernel_addr), 0);
        exp_beats.delete();
        exp_pix.delete();
        exp_bias.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("postrst_quiet", int'(bus.tap_valid) + int'(bus.bias_valid) + int'(bus.busy), 0);
        end

        run_pass(1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
